// File: rtl/m_mem_master.sv
// M-stage data-memory initiator: turns pipeline load/store ops into req/ack bus
// transactions, checks alignment/range, stalls while busy, extends load data.
module m_mem_master #(
    parameter logic [31:0] DM_BASE  = 32'h0000_0000,
    parameter logic [31:0] DM_LIMIT = 32'h0000_2FFF,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [3:0]  m_op,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic        m_flush,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        m_stall,
    output logic [31:0] m_rdata,
    output logic        m_rdata_valid,
    output logic        exc,
    output logic [4:0]  exc_code
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [3:0]  OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
                            OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;
    localparam logic [31:0] SPAN     = DM_LIMIT - DM_BASE;
    localparam logic [3:0]  TMO_LAST = 4'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [3:0]  r_op;
    logic [1:0]  r_lane;
    logic        r_load, r_cancel, r_tmo;
    logic [3:0]  r_cnt;

    logic        w_is_load, w_is_store, w_misaligned, w_out_of_range;
    logic        w_take, w_illegal, w_accept, w_cancel;
    logic [31:0] w_off, w_wdata, w_ext;
    logic [3:0]  w_be;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Decode and legality of the op presented in M.
    assign w_is_load    = (m_op >= OP_LW) && (m_op <= OP_LBU);
    assign w_is_store   = (m_op >= OP_SW) && (m_op <= OP_SB);
    assign w_misaligned = ((m_op == OP_LW || m_op == OP_SW) && m_addr[1:0] != 2'b00) ||
                          ((m_op == OP_LH || m_op == OP_LHU || m_op == OP_SH) && m_addr[0]);
    // Offset from the window base wraps high when addr < DM_BASE, so one compare covers both bounds.
    assign w_off          = m_addr - DM_BASE;
    assign w_out_of_range = w_off > SPAN;

    assign w_take    = (r_state == S_IDLE) && m_valid && (w_is_load || w_is_store) && !m_flush;
    assign w_illegal = w_take && (w_misaligned || w_out_of_range);
    assign w_accept  = w_take && !w_illegal;
    assign w_cancel  = r_cancel || m_flush;

    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = m_wdata;
        case (m_op)
            OP_SH: begin
                w_be    = 4'b0011 << {m_addr[1], 1'b0};
                w_wdata = {2{m_wdata[15:0]}};
            end
            OP_SB: begin
                w_be    = 4'b0001 << m_addr[1:0];
                w_wdata = {4{m_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    assign w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    assign w_byte = bus_rdata[8*r_lane +: 8];

    always_comb begin
        w_ext = bus_rdata;
        case (r_op)
            OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_ext = {16'h0, w_half};
            OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_ext = {24'h0, w_byte};
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_BUSY;
            S_BUSY: begin
                // A flushed transaction still waits for its ack, then disappears silently.
                if (bus_ack || r_cnt == TMO_LAST)
                    w_next = w_cancel ? S_IDLE : S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        m_stall       = w_accept || (r_state == S_BUSY);
        m_rdata_valid = (r_state == S_DONE) && r_load && !r_tmo;
        exc           = 1'b0;
        exc_code      = 5'd0;
        if (w_illegal) begin
            exc      = 1'b1;
            exc_code = w_is_load ? 5'd4 : 5'd5;
        end else if (r_state == S_DONE && r_tmo) begin
            exc      = 1'b1;
            exc_code = 5'd7;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 4'd0;
            r_lane    <= 2'd0;
            r_load    <= 1'b0;
            r_cancel  <= 1'b0;
            r_tmo     <= 1'b0;
            r_cnt     <= 4'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            m_rdata   <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                bus_req   <= 1'b1;
                bus_we    <= w_is_store;
                bus_addr  <= {m_addr[31:2], 2'b00};
                bus_be    <= w_be;
                bus_wdata <= w_wdata;
                r_op      <= m_op;
                r_lane    <= m_addr[1:0];
                r_load    <= w_is_load;
                r_cancel  <= 1'b0;
                r_tmo     <= 1'b0;
                r_cnt     <= 4'd0;
            end
            if (r_state == S_BUSY) begin
                if (m_flush) r_cancel <= 1'b1;
                if (bus_ack) begin
                    bus_req <= 1'b0;
                    r_cnt   <= 4'd0;
                    if (r_load && !w_cancel) m_rdata <= w_ext;
                end else if (r_cnt == TMO_LAST) begin
                    bus_req <= 1'b0;
                    r_cnt   <= 4'd0;
                    r_tmo   <= !w_cancel;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end
    end

endmodule
